// File: rtl/mem_io_unit_if.sv
// Bus bundle between the MEM stage, the data-memory BRAM and the I/O space.
// The unit uses the slave modport; the surrounding pipeline/memory side uses master.
interface mem_io_unit_if;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        io_read_i;
  logic        io_write_i;
  logic [1:0]  byte_or_word_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        dmem_re_o;
  logic        dmem_we_o;
  logic [13:0] dmem_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        io_req_o;
  logic        io_we_o;
  logic [7:0]  io_addr_o;
  logic [31:0] io_rdata_i;
  logic        io_ack_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        io_timeout_o;

  modport slave (
    input  mem_read_i, mem_write_i, io_read_i, io_write_i, byte_or_word_i,
    input  addr_i, wdata_i, dmem_rdata_i, io_rdata_i, io_ack_i,
    output dmem_re_o, dmem_we_o, dmem_addr_o, bus_wdata_o,
    output io_req_o, io_we_o, io_addr_o,
    output stall_o, rdata_o, rdata_valid_o, io_timeout_o
  );

  modport master (
    output mem_read_i, mem_write_i, io_read_i, io_write_i, byte_or_word_i,
    output addr_i, wdata_i, dmem_rdata_i, io_rdata_i, io_ack_i,
    input  dmem_re_o, dmem_we_o, dmem_addr_o, bus_wdata_o,
    input  io_req_o, io_we_o, io_addr_o,
    input  stall_o, rdata_o, rdata_valid_o, io_timeout_o
  );
endinterface

// File: rtl/mem_io_unit.sv
// MEM-stage load/store unit: zero-stall stores, 2-stall BRAM loads, handshaked I/O.
// Optional I/O watchdog enabled with `define IO_TIMEOUT_EN.
module mem_io_unit (
  input  logic         clk_i,
  input  logic         rst_n_i,
  mem_io_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, MEM_RD = 2'd1, IO_WAIT = 2'd2, DONE = 2'd3} stateT;

  stateT       stateReg, stateNext;
  logic        ioWeReg;
  logic [7:0]  ioAddrReg;
  logic [31:0] wdataReg;
  logic [31:0] rdataReg;
  logic [1:0]  widthReg;
  logic [1:0]  laneReg;
  logic        loadReg;
  logic        selIoWr, selIoRd, selMemWr, selMemRd, selIo;
  logic        dmemRe, dmemWe, stall;
  logic        timeoutHit;
  logic [15:0] unusedAddr;

  assign unusedAddr = bus.addr_i[31:16];

  function automatic logic [31:0] formatLoad(input logic [31:0] word,
                                             input logic [1:0]  width,
                                             input logic [1:0]  lane);
    logic [7:0] laneByte;
    case (lane)
      2'd0:    laneByte = word[7:0];
      2'd1:    laneByte = word[15:8];
      2'd2:    laneByte = word[23:16];
      default: laneByte = word[31:24];
    endcase
    case (width)
      2'b00:   formatLoad = {{24{laneByte[7]}}, laneByte};
      2'b10:   formatLoad = {24'h0, laneByte};
      default: formatLoad = word;
    endcase
  endfunction

  // Fixed strobe priority: io_write > io_read > mem_write > mem_read
  assign selIoWr  = bus.io_write_i;
  assign selIoRd  = !bus.io_write_i && bus.io_read_i;
  assign selMemWr = !bus.io_write_i && !bus.io_read_i && bus.mem_write_i;
  assign selMemRd = !bus.io_write_i && !bus.io_read_i && !bus.mem_write_i && bus.mem_read_i;
  assign selIo    = selIoWr || selIoRd;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stateReg <= IDLE;
    else          stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    dmemRe    = 1'b0;
    dmemWe    = 1'b0;
    stall     = 1'b0;
    case (stateReg)
      IDLE: begin
        if (selIo) begin
          stall     = 1'b1;
          stateNext = IO_WAIT;
        end else if (selMemWr) begin
          dmemWe    = 1'b1;
        end else if (selMemRd) begin
          dmemRe    = 1'b1;
          stall     = 1'b1;
          stateNext = MEM_RD;
        end
      end
      MEM_RD: begin
        stall     = 1'b1;
        stateNext = DONE;
      end
      IO_WAIT: begin
        stall = 1'b1;
        if (bus.io_ack_i || timeoutHit) stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ioWeReg   <= 1'b0;
      ioAddrReg <= 8'h0;
      wdataReg  <= 32'h0;
      rdataReg  <= 32'h0;
      widthReg  <= 2'b00;
      laneReg   <= 2'b00;
      loadReg   <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          widthReg <= bus.byte_or_word_i;
          laneReg  <= bus.addr_i[1:0];
          loadReg  <= selIoRd || selMemRd;
          if (selIo) begin
            ioWeReg   <= selIoWr;
            ioAddrReg <= bus.addr_i[7:0];
            wdataReg  <= bus.wdata_i;
          end
        end
        MEM_RD: rdataReg <= formatLoad(bus.dmem_rdata_i, widthReg, laneReg);
        IO_WAIT: begin
          // Ack wins over a timeout landing in the same cycle
          if (bus.io_ack_i)     rdataReg <= formatLoad(bus.io_rdata_i, widthReg, laneReg);
          else if (timeoutHit)  rdataReg <= 32'h0;
        end
        default: ;
      endcase
    end
  end

`ifdef IO_TIMEOUT_EN
  logic [7:0] toCount;
  logic       timeoutReg;

  // Counts IO_WAIT cycles; the 255th unacknowledged cycle aborts the access
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      toCount    <= 8'd0;
      timeoutReg <= 1'b0;
    end else begin
      toCount    <= (stateReg == IO_WAIT) ? toCount + 8'd1 : 8'd0;
      timeoutReg <= timeoutHit;
    end
  end

  assign timeoutHit       = (stateReg == IO_WAIT) && !bus.io_ack_i && (toCount == 8'd254);
  assign bus.io_timeout_o = timeoutReg;
`else
  assign timeoutHit       = 1'b0;
  assign bus.io_timeout_o = 1'b0;
`endif

  // Combinational outputs are forced low while reset is asserted
  assign bus.dmem_re_o     = dmemRe && rst_n_i;
  assign bus.dmem_we_o     = dmemWe && rst_n_i;
  assign bus.stall_o       = stall && rst_n_i;
  assign bus.dmem_addr_o   = rst_n_i ? bus.addr_i[15:2] : 14'h0;
  assign bus.bus_wdata_o   = !rst_n_i ? 32'h0 : ((stateReg == IO_WAIT) ? wdataReg : bus.wdata_i);
  assign bus.io_req_o      = (stateReg == IO_WAIT);
  assign bus.io_we_o       = ioWeReg;
  assign bus.io_addr_o     = ioAddrReg;
  assign bus.rdata_o       = rdataReg;
  assign bus.rdata_valid_o = (stateReg == DONE) && loadReg;
endmodule
